mips_alu_pipelined: RTL and testbench

// - Integer ALU for the 7-stage MIPS pipeline (IF,IG,ID,EX,MM,WA,WB); sits in EX, result consumed in MM.
// - Decode is pre-registered one cycle early from ID-stage fields, so the EX cycle holds only the datapath.
// - Output is registered: this result feeds dmem address, MM->EX forwarding and WA write-back.

---
 rtl/mips_pkg.sv | 58 +++++
 rtl/mips_alu_decode.sv | 46 ++++
 rtl/mips_alu_pipelined.sv | 75 +++++++
 tb/tb_mips_alu_pipelined.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encodings and ALU control types used by the EX-stage ALU and its decoder.
package mips_pkg;

    localparam logic [5:0] INST_RTYPE = 6'h00;
    localparam logic [5:0] INST_J     = 6'h02;
    localparam logic [5:0] INST_BEQ   = 6'h04;
    localparam logic [5:0] INST_BNE   = 6'h05;
    localparam logic [5:0] INST_ADDI  = 6'h08;
    localparam logic [5:0] INST_ADDIU = 6'h09;
    localparam logic [5:0] INST_SLTI  = 6'h0A;
    localparam logic [5:0] INST_SLTIU = 6'h0B;
    localparam logic [5:0] INST_ANDI  = 6'h0C;
    localparam logic [5:0] INST_ORI   = 6'h0D;
    localparam logic [5:0] INST_XORI  = 6'h0E;
    localparam logic [5:0] INST_LUI   = 6'h0F;
    localparam logic [5:0] INST_LW    = 6'h23;
    localparam logic [5:0] INST_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_SLLV = 6'h04;
    localparam logic [5:0] FUNCT_SRLV = 6'h06;
    localparam logic [5:0] FUNCT_SRAV = 6'h07;
    localparam logic [5:0] FUNCT_JR   = 6'h08;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        OP_ZERO, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR,
        OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_LUI
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_RT, SRCB_SE_IMM, SRCB_ZE_IMM
    } srcb_sel_e;

    typedef enum logic {
        SHAMT_FIELD, SHAMT_RS
    } shamt_sel_e;

    typedef struct packed {
        alu_op_e    op;
        srcb_sel_e  srcb;
        shamt_sel_e shsel;
    } alu_ctrl_t;

    localparam alu_ctrl_t ALU_CTRL_ZERO = '{op: OP_ZERO, srcb: SRCB_RT, shsel: SHAMT_FIELD};

endpackage

// File: rtl/mips_alu_decode.sv
// Combinational opcode/funct decode into ALU operation, operand-B source and shift-amount source.
module mips_alu_decode
    import mips_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output alu_ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = ALU_CTRL_ZERO;
        if (i_opcode == INST_RTYPE) begin
            case (i_funct)
                FUNCT_SLL:  o_ctrl.op = OP_SLL;
                FUNCT_SRL:  o_ctrl.op = OP_SRL;
                FUNCT_SRA:  o_ctrl.op = OP_SRA;
                FUNCT_SLLV: begin o_ctrl.op = OP_SLL; o_ctrl.shsel = SHAMT_RS; end
                FUNCT_SRLV: begin o_ctrl.op = OP_SRL; o_ctrl.shsel = SHAMT_RS; end
                FUNCT_SRAV: begin o_ctrl.op = OP_SRA; o_ctrl.shsel = SHAMT_RS; end
                FUNCT_ADD, FUNCT_ADDU: o_ctrl.op = OP_ADD;
                FUNCT_SUB, FUNCT_SUBU: o_ctrl.op = OP_SUB;
                FUNCT_AND:  o_ctrl.op = OP_AND;
                FUNCT_OR:   o_ctrl.op = OP_OR;
                FUNCT_XOR:  o_ctrl.op = OP_XOR;
                FUNCT_NOR:  o_ctrl.op = OP_NOR;
                FUNCT_SLT:  o_ctrl.op = OP_SLT;
                FUNCT_SLTU: o_ctrl.op = OP_SLTU;
                default:    o_ctrl.op = OP_ZERO;
            endcase
        end else begin
            case (i_opcode)
                INST_ADDI, INST_ADDIU, INST_LW, INST_SW: begin
                    o_ctrl.op = OP_ADD;  o_ctrl.srcb = SRCB_SE_IMM;
                end
                INST_SLTI:  begin o_ctrl.op = OP_SLT;  o_ctrl.srcb = SRCB_SE_IMM; end
                INST_SLTIU: begin o_ctrl.op = OP_SLTU; o_ctrl.srcb = SRCB_SE_IMM; end
                INST_ANDI:  begin o_ctrl.op = OP_AND;  o_ctrl.srcb = SRCB_ZE_IMM; end
                INST_ORI:   begin o_ctrl.op = OP_OR;   o_ctrl.srcb = SRCB_ZE_IMM; end
                INST_XORI:  begin o_ctrl.op = OP_XOR;  o_ctrl.srcb = SRCB_ZE_IMM; end
                INST_LUI:   o_ctrl.op = OP_LUI;
                default:    o_ctrl.op = OP_ZERO;
            endcase
        end
    end

endmodule

// File: rtl/mips_alu_pipelined.sv
// EX-stage integer ALU: decode is registered from the ID-stage fields so EX only carries the datapath.
module mips_alu_pipelined
    import mips_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [5:0]      opcode_fwd,
    input  logic [5:0]      funct_fwd,
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic [XLEN-1:0] rrs,
    input  logic [XLEN-1:0] rrt_in,
    input  logic [15:0]     imm,
    input  logic [4:0]      shamt_in,
    output logic [XLEN-1:0] rslt
);

    alu_ctrl_t       w_ctrl_next;
    alu_ctrl_t       r_opsel;
    logic [XLEN-1:0] w_srcb;
    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_result;

    mips_alu_decode u_decode (
        .i_opcode (opcode_fwd),
        .i_funct  (funct_fwd),
        .o_ctrl   (w_ctrl_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opsel <= ALU_CTRL_ZERO;
            rslt    <= '0;
        end else begin
            r_opsel <= w_ctrl_next;
            rslt    <= w_result;
        end
    end

    always_comb begin
        case (r_opsel.srcb)
            SRCB_SE_IMM: w_srcb = {{(XLEN-16){imm[15]}}, imm};
            SRCB_ZE_IMM: w_srcb = {{(XLEN-16){1'b0}}, imm};
            default:     w_srcb = rrt_in;
        endcase
        w_shamt = (r_opsel.shsel == SHAMT_RS) ? rrs[4:0] : shamt_in;
    end

    always_comb begin
        w_result = '0;
        case (r_opsel.op)
            OP_ADD:  w_result = rrs + w_srcb;
            OP_SUB:  w_result = rrs - w_srcb;
            OP_AND:  w_result = rrs & w_srcb;
            OP_OR:   w_result = rrs | w_srcb;
            OP_XOR:  w_result = rrs ^ w_srcb;
            OP_NOR:  w_result = ~(rrs | w_srcb);
            OP_SLT:  w_result = {{(XLEN-1){1'b0}}, ($signed(rrs) < $signed(w_srcb))};
            OP_SLTU: w_result = {{(XLEN-1){1'b0}}, (rrs < w_srcb)};
            OP_SLL:  w_result = rrt_in << w_shamt;
            OP_SRL:  w_result = rrt_in >> w_shamt;
            OP_SRA:  w_result = $signed(rrt_in) >>> w_shamt;
            OP_LUI:  w_result = {imm, {(XLEN-16){1'b0}}};
            default: w_result = '0;
        endcase
    end

    // EX fields must be last cycle's ID fields; opsel alone drives the datapath.
    a_fwd_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        {opcode, funct} == $past({opcode_fwd, funct_fwd}))
        else $error("opcode/funct in EX differ from previous opcode_fwd/funct_fwd");

endmodule

// File: tb/tb_mips_alu_pipelined.sv
// Directed bench for the pipelined MIPS ALU: hand-computed results at one-cycle latency after EX.
module tb_mips_alu_pipelined;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode_fwd = '0;
    logic [5:0]  funct_fwd = '0;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic [31:0] rrs = '0;
    logic [31:0] rrt_in = '0;
    logic [15:0] imm = '0;
    logic [4:0]  shamt_in = '0;
    logic [31:0] rslt;

    int checks = 0;
    int errors = 0;
    logic [5:0] prev_op = '0;
    logic [5:0] prev_fn = '0;

    localparam logic [5:0] FILL = 6'h3F;

    mips_alu_pipelined #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode_fwd (opcode_fwd),
        .funct_fwd  (funct_fwd),
        .opcode     (opcode),
        .funct      (funct),
        .rrs        (rrs),
        .rrt_in     (rrt_in),
        .imm        (imm),
        .shamt_in   (shamt_in),
        .rslt       (rslt)
    );

    always #5 clk = ~clk;

    // One pipeline cycle: new instruction enters ID, previous ID instruction occupies EX with these operands.
    task automatic step(input logic [5:0] fop, input logic [5:0] ffn, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [15:0] im, input logic [4:0] sh);
        opcode     = prev_op;
        funct      = prev_fn;
        opcode_fwd = fop;
        funct_fwd  = ffn;
        rrs        = rs;
        rrt_in     = rt;
        imm        = im;
        shamt_in   = sh;
        prev_op    = fop;
        prev_fn    = ffn;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if (rslt !== 32'h0) begin
            errors++;
            $display("FAIL reset_value got=%h exp=%h", rslt, 32'h0);
        end
        step(FILL, 6'h00, 32'h0, 32'h0, 16'h0, 5'd0);
        rst_n = 1'b1;
        step(FILL, 6'h00, 32'h0, 32'h0, 16'h0, 5'd0);
    endtask

    task automatic test_rformat;
        logic [5:0]  fn  [14] = '{6'h21, 6'h20, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                  6'h2A, 6'h2B, 6'h2A, 6'h00, 6'h02, 6'h08};
        logic [31:0] rs  [14] = '{32'h7, 32'h7FFFFFFF, 32'h0, 32'h5, 32'hF0F0, 32'hF0F0, 32'hFF00FF00, 32'h0,
                                  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 32'h1234};
        logic [31:0] rt  [14] = '{32'hFFFFFFFF, 32'h1, 32'h1, 32'h7, 32'hFF00, 32'hFF00, 32'hFFFF0000, 32'h0,
                                  32'h1, 32'h1, 32'hFFFFFFFF, 32'h1, 32'h80000000, 32'h5};
        logic [4:0]  sh  [14] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0,
                                  5'd0, 5'd0, 5'd0, 5'd31, 5'd4, 5'd0};
        logic [31:0] exp [14] = '{32'h6, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hF000, 32'hFFF0,
                                  32'h00FFFF00, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 32'h80000000,
                                  32'h08000000, 32'h0};
        for (int i = 0; i < 14; i++) begin
            step(6'h00, fn[i], 32'h0, 32'h0, 16'h0, 5'd0);
            step(FILL, 6'h00, rs[i], rt[i], 16'hA5A5, sh[i]);
            checks++;
            if (rslt !== exp[i]) begin
                errors++;
                $display("FAIL rformat[%0d] funct=%h got=%h exp=%h", i, fn[i], rslt, exp[i]);
            end
        end
    endtask

    task automatic test_iformat;
        logic [5:0]  op  [13] = '{6'h08, 6'h09, 6'h0D, 6'h0F, 6'h0B, 6'h0A, 6'h0C, 6'h0E,
                                  6'h2B, 6'h04, 6'h02, 6'h05, 6'h0A};
        logic [31:0] rs  [13] = '{32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h5, 32'hFFFFFFFE, 32'hFFFFFFFF,
                                  32'hFFFF0000, 32'h10, 32'h3, 32'h1, 32'h4, 32'h1};
        logic [15:0] im  [13] = '{16'h8000, 16'h0001, 16'h8000, 16'h1234, 16'hFFFF, 16'hFFFF, 16'h8000,
                                  16'hFFFF, 16'h0004, 16'h0010, 16'h0100, 16'h0020, 16'hFFFF};
        logic [31:0] exp [13] = '{32'hFFFF8000, 32'h0, 32'h00008000, 32'h12340000, 32'h1, 32'h1,
                                  32'h00008000, 32'hFFFFFFFF, 32'h14, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 13; i++) begin
            step(op[i], 6'h15, 32'h0, 32'h0, 16'h0, 5'd0);
            step(FILL, 6'h00, rs[i], 32'h3, im[i], 5'd7);
            checks++;
            if (rslt !== exp[i]) begin
                errors++;
                $display("FAIL iformat[%0d] opcode=%h got=%h exp=%h", i, op[i], rslt, exp[i]);
            end
        end
    endtask

    task automatic test_shifts;
        logic [5:0]  fn  [5] = '{6'h03, 6'h06, 6'h07, 6'h03, 6'h04};
        logic [31:0] rs  [5] = '{32'h0, 32'd36, 32'h1, 32'hFFFFFFFF, 32'h21};
        logic [31:0] rt  [5] = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000001, 32'h3};
        logic [4:0]  sh  [5] = '{5'd4, 5'd9, 5'd9, 5'd0, 5'd0};
        logic [31:0] exp [5] = '{32'hF8000000, 32'h08000000, 32'hC0000000, 32'h80000001, 32'h6};
        for (int i = 0; i < 5; i++) begin
            step(6'h00, fn[i], 32'h0, 32'h0, 16'h0, 5'd0);
            step(FILL, 6'h00, rs[i], rt[i], 16'h0, sh[i]);
            checks++;
            if (rslt !== exp[i]) begin
                errors++;
                $display("FAIL shift[%0d] funct=%h got=%h exp=%h", i, fn[i], rslt, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        step(6'h00, 6'h21, 32'h0, 32'h0, 16'h0, 5'd0);
        step(6'h00, 6'h23, 32'h10, 32'h20, 16'h0, 5'd0);
        checks++;
        if (rslt !== 32'h30) begin errors++; $display("FAIL stream_addu got=%h exp=%h", rslt, 32'h30); end
        step(6'h00, 6'h24, 32'h5, 32'h7, 16'h0, 5'd0);
        checks++;
        if (rslt !== 32'hFFFFFFFE) begin errors++; $display("FAIL stream_subu got=%h exp=%h", rslt, 32'hFFFFFFFE); end
        step(6'h23, 6'h00, 32'hF0F0, 32'hFF00, 16'h0, 5'd0);
        checks++;
        if (rslt !== 32'hF000) begin errors++; $display("FAIL stream_and got=%h exp=%h", rslt, 32'hF000); end
        step(FILL, 6'h00, 32'h100, 32'h0, 16'hFFFC, 5'd0);
        checks++;
        if (rslt !== 32'hFC) begin errors++; $display("FAIL stream_lw got=%h exp=%h", rslt, 32'hFC); end
    endtask

    task automatic test_reset_midstream;
        step(6'h00, 6'h21, 32'h0, 32'h0, 16'h0, 5'd0);
        step(6'h00, 6'h21, 32'h1, 32'h2, 16'h0, 5'd0);
        checks++;
        if (rslt !== 32'h3) begin errors++; $display("FAIL pre_reset got=%h exp=%h", rslt, 32'h3); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rslt !== 32'h0) begin errors++; $display("FAIL async_reset got=%h exp=%h", rslt, 32'h0); end
        // ADDU enters ID while reset is held, so opsel is never loaded with it.
        step(6'h00, 6'h21, 32'h9, 32'h9, 16'h0, 5'd0);
        checks++;
        if (rslt !== 32'h0) begin errors++; $display("FAIL reset_hold got=%h exp=%h", rslt, 32'h0); end
        rst_n = 1'b1;
        step(6'h00, 6'h21, 32'h5, 32'h6, 16'h0, 5'd0);
        checks++;
        if (rslt !== 32'h0) begin errors++; $display("FAIL post_release_zero got=%h exp=%h", rslt, 32'h0); end
        step(FILL, 6'h00, 32'h5, 32'h6, 16'h0, 5'd0);
        checks++;
        if (rslt !== 32'hB) begin errors++; $display("FAIL post_release_addu got=%h exp=%h", rslt, 32'hB); end
    endtask

    initial begin
        test_reset();
        test_rformat();
        test_iformat();
        test_shifts();
        test_back_to_back();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
